// File: rtl/wide_add_seq.sv
// -----------------------------------------------------------------------------
// wide_add_seq
//   Multi-cycle WORDS x 32-bit add/subtract. A single shared 32-bit ripple
//   carry adder (rca_32_bit) is stepped across the operands one limb per
//   clock, LSB limb first, with the inter-limb carry held in a register.
//
// Ports
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   request, sampled only while idle
//   sub     in   0: A+B, 1: A-B (sampled with start)
//   op_a    in   W-bit operand A (sampled with start)
//   op_b    in   W-bit operand B (sampled with start)
//   busy    out  operation in progress
//   done    out  one-cycle pulse when result/cout/ovf update
//   result  out  W-bit result of the last completed operation
//   cout    out  carry out of the top limb (subtract: 1 = no borrow)
//   ovf     out  two's-complement signed overflow of the last result
// -----------------------------------------------------------------------------

// 32-bit ripple-carry adder; the only adder in the wide path.
module rca_32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic        cout,
  output logic [31:0] sum
);

  logic [32:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[32];

endmodule

module wide_add_seq #(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [32*WORDS-1:0]   op_a,
  input  logic [32*WORDS-1:0]   op_b,
  output logic                  busy,
  output logic                  done,
  output logic [32*WORDS-1:0]   result,
  output logic                  cout,
  output logic                  ovf
);

  localparam int unsigned LIMB_W = 32;
  localparam int unsigned W      = LIMB_W * WORDS;
  localparam int unsigned IDX_W  = $clog2(WORDS);
  localparam int unsigned LAST   = WORDS - 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Operands and accumulator are kept limb-addressable.
  logic [WORDS-1:0][LIMB_W-1:0] a_q,   a_d;
  logic [WORDS-1:0][LIMB_W-1:0] b_q,   b_d;
  logic [WORDS-1:0][LIMB_W-1:0] acc_q, acc_d;

  logic [IDX_W-1:0] idx_q,    idx_d;
  logic             carry_q,  carry_d;
  logic [W-1:0]     result_q, result_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;
  logic             done_q,   done_d;
  logic             busy_q,   busy_d;

  logic [LIMB_W-1:0] add_a;
  logic [LIMB_W-1:0] add_b;
  logic [LIMB_W-1:0] add_sum;
  logic              add_cout;
  logic              last_limb;

  // Limb select feeding the shared adder.
  assign add_a     = a_q[idx_q];
  assign add_b     = b_q[idx_q];
  assign last_limb = (idx_q == IDX_W'(LAST));

  rca_32_bit u_rca (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .cout (add_cout),
    .sum  (add_sum)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = RUN;
      RUN:     if (last_limb) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    busy_d   = (state_d == RUN);

    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtract as A + ~B + 1: the +1 enters through the initial carry.
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub;
          idx_d   = '0;
        end
      end
      RUN: begin
        acc_d[idx_q] = add_sum;
        carry_d      = add_cout;
        idx_d        = idx_q + IDX_W'(1);
        if (last_limb) begin
          // Publish the completed result including the limb just summed.
          result_d = acc_d;
          cout_d   = add_cout;
          ovf_d    = (a_q[LAST][LIMB_W-1] == b_q[LAST][LIMB_W-1]) &&
                     (add_sum[LIMB_W-1] != a_q[LAST][LIMB_W-1]);
          done_d   = 1'b1;
          idx_d    = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// -----------------------------------------------------------------------------
// tb_wide_add_seq
//   Directed bench for wide_add_seq (WORDS=4). Each accepted request pushes its
//   expected result/cout/ovf and accept cycle into a queue; a negedge monitor
//   pops on every done and checks values, latency, busy duration and that the
//   result holds between completions.
// -----------------------------------------------------------------------------
module tb_wide_add_seq;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 32 * WORDS;

  typedef struct {
    logic [W-1:0] r;
    logic         co;
    logic         ov;
    int           acc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   busy_cnt = 0;
  logic [W-1:0] last_res = '0;
  exp_t sb[$];

  wide_add_seq #(.WORDS(WORDS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int i = 0; i < WORDS; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Drive a request at the current negedge (DUT idle) and record expectations.
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t       e;
    logic [W:0] full;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    sub   = s;
    if (s) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else   full = {1'b0, a} + {1'b0, b};
    e.r  = full[W-1:0];
    e.co = full[W];
    if (s) e.ov = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
    else   e.ov = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op_a  = rand_w();
    op_b  = rand_w();
    sub   = 1'($urandom);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("issue_wait_busy", W'(busy), W'(0));
    drive(a, b, s);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", W'(done), W'(1));
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
      last_res = '0;
    end else begin
      if (done) begin
        chk("done_without_request", W'(sb.size() == 0), W'(0));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("result", result, e.r);
          chk("cout", W'(cout), W'(e.co));
          chk("ovf", W'(ovf), W'(e.ov));
          chk("latency", W'(cyc - e.acc), W'(WORDS));
          chk("busy_cycles", W'(busy_cnt), W'(WORDS));
          chk("busy_low_at_done", W'(busy), W'(0));
          last_res = e.r;
        end
        busy_cnt = 0;
      end else begin
        chk("result_hold", result, last_res);
      end
      if (busy) busy_cnt++;
    end
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    op_a  = '0;
    op_b  = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_result", result, '0);
    chk("rst_cout", W'(cout), W'(0));
    chk("rst_ovf", W'(ovf), W'(0));
    repeat (10) @(negedge clk);

    // Full carry ripple through every limb.
    issue({W{1'b1}}, W'(1), 1'b0);
    wait_done();

    // Repeated pattern with signed overflow; single inter-limb carry.
    a = {WORDS{32'h3EBF3EBF}};
    b = {WORDS{32'h55555555}};
    issue(a, b, 1'b0);
    wait_done();
    issue(W'(32'hFFFF_FFFF), W'(1), 1'b0);
    wait_done();

    // Subtract: borrow, and most-negative minus one.
    issue(W'(5), W'(7), 1'b1);
    wait_done();
    a = '0;
    a[W-1] = 1'b1;
    issue(a, W'(1), 1'b1);
    wait_done();

    // Start pulses while busy are ignored; start in the done cycle is taken.
    issue(W'(32'h1234_5678), W'(32'h0FED_CBA9), 1'b0);
    start = 1'b1;
    op_a  = rand_w();
    op_b  = rand_w();
    sub   = 1'b1;
    @(negedge clk);
    op_a  = rand_w();
    @(negedge clk);
    start = 1'b0;
    wait_done();
    drive(rand_w(), rand_w(), 1'b1);
    wait_done();

    // Back-to-back random operations.
    for (int i = 0; i < 6; i++) begin
      wait_done();
      drive(rand_w(), rand_w(), 1'($urandom));
    end
    wait_done();

    // Reset in the middle of an operation aborts it.
    issue(rand_w(), rand_w(), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", W'(busy), W'(0));
    chk("midrst_done", W'(done), W'(0));
    chk("midrst_result", result, '0);
    chk("midrst_cout", W'(cout), W'(0));
    chk("midrst_ovf", W'(ovf), W'(0));
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    issue(W'(7), W'(9), 1'b0);
    wait_done();

    repeat (3) @(negedge clk);
    chk("sb_drained", W'(sb.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
